// File: rtl/pr_region_freeze_ctrl.sv
// Per-region partial-reconfiguration freeze controller: answers the software
// freeze/unfreeze handshake and drives the region's freeze, reset and stop signals.
module pr_region_freeze_ctrl #(
    parameter int STOP_TIMEOUT  = 256,
    parameter int UNFREEZE_WAIT = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       freeze_req,
    input  logic       unfreeze_req,
    input  logic       reset_req,
    output logic       freeze_status,
    output logic       unfreeze_status,
    output logic [1:0] illegal_req,
    output logic       timed_out,
    output logic       stop_req,
    input  logic       stop_ack,
    output logic       region_freeze,
    output logic       region_reset
);

    localparam int MAX_WAIT = (STOP_TIMEOUT > UNFREEZE_WAIT) ? STOP_TIMEOUT : UNFREEZE_WAIT;
    localparam int CNT_W    = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        FREEZING   = 2'd1,
        FROZEN     = 2'd2,
        UNFREEZING = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               fr_q, ur_q;
    logic               freeze_status_q, freeze_status_d;
    logic               unfreeze_status_q, unfreeze_status_d;
    logic [1:0]         illegal_q, illegal_d;
    logic               timed_out_q, timed_out_d;
    logic               stop_req_q, stop_req_d;
    logic               region_freeze_q, region_freeze_d;
    logic               region_reset_q, region_reset_d;
    logic               fr_rise, ur_rise;

    assign fr_rise = freeze_req & ~fr_q;
    assign ur_rise = unfreeze_req & ~ur_q;

    // Next-state, counter and registered-output computation.
    always_comb begin
        state_d           = state_q;
        cnt_d             = cnt_q;
        freeze_status_d   = freeze_status_q;
        unfreeze_status_d = unfreeze_status_q;
        timed_out_d       = timed_out_q;
        stop_req_d        = stop_req_q;
        region_freeze_d   = region_freeze_q;
        region_reset_d    = 1'b0;

        // An illegal bit is held while its request level stays high; setting wins.
        illegal_d[0] = (fr_rise & ((state_q != RUN) | ur_rise)) | (illegal_q[0] & freeze_req);
        illegal_d[1] = (ur_rise & ((state_q != FROZEN) | fr_rise)) | (illegal_q[1] & unfreeze_req);

        case (state_q)
            RUN: begin
                if (fr_rise && !ur_rise) begin
                    state_d           = FREEZING;
                    stop_req_d        = 1'b1;
                    unfreeze_status_d = 1'b0;
                    timed_out_d       = 1'b0;
                    cnt_d             = '0;
                end else begin
                    state_d = RUN;
                end
            end
            FREEZING: begin
                if (stop_ack || (cnt_q == CNT_W'(STOP_TIMEOUT - 1))) begin
                    state_d         = FROZEN;
                    timed_out_d     = ~stop_ack;
                    stop_req_d      = 1'b0;
                    region_freeze_d = 1'b1;
                    freeze_status_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            FROZEN: begin
                if (ur_rise && !fr_rise) begin
                    state_d         = UNFREEZING;
                    freeze_status_d = 1'b0;
                    region_reset_d  = 1'b0;
                    cnt_d           = '0;
                end else begin
                    region_reset_d  = reset_req;
                end
            end
            UNFREEZING: begin
                if (cnt_q == CNT_W'(UNFREEZE_WAIT - 1)) begin
                    state_d           = RUN;
                    region_freeze_d   = 1'b0;
                    unfreeze_status_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // State, counter, edge-detect and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q           <= RUN;
            cnt_q             <= '0;
            fr_q              <= 1'b0;
            ur_q              <= 1'b0;
            freeze_status_q   <= 1'b0;
            unfreeze_status_q <= 1'b0;
            illegal_q         <= 2'b00;
            timed_out_q       <= 1'b0;
            stop_req_q        <= 1'b0;
            region_freeze_q   <= 1'b0;
            region_reset_q    <= 1'b0;
        end else begin
            state_q           <= state_d;
            cnt_q             <= cnt_d;
            fr_q              <= freeze_req;
            ur_q              <= unfreeze_req;
            freeze_status_q   <= freeze_status_d;
            unfreeze_status_q <= unfreeze_status_d;
            illegal_q         <= illegal_d;
            timed_out_q       <= timed_out_d;
            stop_req_q        <= stop_req_d;
            region_freeze_q   <= region_freeze_d;
            region_reset_q    <= region_reset_d;
        end
    end

    assign freeze_status   = freeze_status_q;
    assign unfreeze_status = unfreeze_status_q;
    assign illegal_req     = illegal_q;
    assign timed_out       = timed_out_q;
    assign stop_req        = stop_req_q;
    assign region_freeze   = region_freeze_q;
    assign region_reset    = region_reset_q;

endmodule

// File: tb/tb_pr_region_freeze_ctrl.sv
// Directed bench for pr_region_freeze_ctrl with STOP_TIMEOUT=8, UNFREEZE_WAIT=4.
module tb_pr_region_freeze_ctrl;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       freeze_req = 1'b0;
    logic       unfreeze_req = 1'b0;
    logic       reset_req = 1'b0;
    logic       stop_ack = 1'b0;
    logic       freeze_status, unfreeze_status, timed_out, stop_req;
    logic       region_freeze, region_reset;
    logic [1:0] illegal_req;
    logic [7:0] obs;
    int         pass_cnt = 0;
    int         total_cnt = 0;

    pr_region_freeze_ctrl #(.STOP_TIMEOUT(8), .UNFREEZE_WAIT(4)) dut (
        .clk(clk), .reset_n(reset_n), .freeze_req(freeze_req),
        .unfreeze_req(unfreeze_req), .reset_req(reset_req),
        .freeze_status(freeze_status), .unfreeze_status(unfreeze_status),
        .illegal_req(illegal_req), .timed_out(timed_out), .stop_req(stop_req),
        .stop_ack(stop_ack), .region_freeze(region_freeze), .region_reset(region_reset)
    );

    always #5 clk = ~clk;

    // {freeze_status, unfreeze_status, illegal_req[1:0], timed_out, stop_req, region_freeze, region_reset}
    assign obs = {freeze_status, unfreeze_status, illegal_req, timed_out, stop_req, region_freeze, region_reset};

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        freeze_req = 1'b0; unfreeze_req = 1'b0; reset_req = 1'b0; stop_ack = 1'b0;
        step(2);
        reset_n = 1'b1;
    endtask

    task automatic go_frozen();
        freeze_req = 1'b1;
        step(1);
        freeze_req = 1'b0;
        stop_ack = 1'b1;
        step(1);
        stop_ack = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        total_cnt++;
        if (obs !== 8'b0000_0000) $display("FAIL reset_outputs got %b exp %b", obs, 8'b0000_0000);
        else pass_cnt++;
    endtask

    task automatic test_freeze_ack();
        apply_reset();
        freeze_req = 1'b1;
        step(1);
        total_cnt++;
        if (obs !== 8'b0000_0100) $display("FAIL freeze_stop_req got %b exp %b", obs, 8'b0000_0100);
        else pass_cnt++;
        step(4);
        stop_ack = 1'b1;
        total_cnt++;
        if (obs !== 8'b0000_0100) $display("FAIL freeze_before_ack got %b exp %b", obs, 8'b0000_0100);
        else pass_cnt++;
        step(1);
        total_cnt++;
        if (obs !== 8'b1000_0010) $display("FAIL freeze_by_ack got %b exp %b", obs, 8'b1000_0010);
        else pass_cnt++;
    endtask

    task automatic test_timeout();
        apply_reset();
        freeze_req = 1'b1;
        step(8);
        total_cnt++;
        if (obs !== 8'b0000_0100) $display("FAIL timeout_cycle8 got %b exp %b", obs, 8'b0000_0100);
        else pass_cnt++;
        step(1);
        total_cnt++;
        if (obs !== 8'b1000_1010) $display("FAIL timeout_frozen got %b exp %b", obs, 8'b1000_1010);
        else pass_cnt++;
    endtask

    task automatic test_reset_and_unfreeze();
        apply_reset();
        go_frozen();
        reset_req = 1'b1;
        total_cnt++;
        if (obs !== 8'b1000_0010) $display("FAIL rr_latency got %b exp %b", obs, 8'b1000_0010);
        else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            step(1);
            total_cnt++;
            if (obs !== 8'b1000_0011) $display("FAIL rr_high_%0d got %b exp %b", i, obs, 8'b1000_0011);
            else pass_cnt++;
        end
        reset_req = 1'b0;
        step(1);
        total_cnt++;
        if (obs !== 8'b1000_0010) $display("FAIL rr_low got %b exp %b", obs, 8'b1000_0010);
        else pass_cnt++;
        reset_req = 1'b1;
        unfreeze_req = 1'b1;
        step(1);
        total_cnt++;
        if (obs !== 8'b0000_0010) $display("FAIL unfreeze_start got %b exp %b", obs, 8'b0000_0010);
        else pass_cnt++;
        step(3);
        total_cnt++;
        if (obs !== 8'b0000_0010) $display("FAIL unfreeze_hold got %b exp %b", obs, 8'b0000_0010);
        else pass_cnt++;
        step(1);
        total_cnt++;
        if (obs !== 8'b0100_0000) $display("FAIL unfreeze_done got %b exp %b", obs, 8'b0100_0000);
        else pass_cnt++;
        reset_req = 1'b0;
        unfreeze_req = 1'b0;
    endtask

    task automatic test_illegal();
        apply_reset();
        unfreeze_req = 1'b1;
        step(1);
        total_cnt++;
        if (obs !== 8'b0010_0000) $display("FAIL illegal_ur_set got %b exp %b", obs, 8'b0010_0000);
        else pass_cnt++;
        step(1);
        total_cnt++;
        if (obs !== 8'b0010_0000) $display("FAIL illegal_ur_hold got %b exp %b", obs, 8'b0010_0000);
        else pass_cnt++;
        unfreeze_req = 1'b0;
        step(1);
        total_cnt++;
        if (obs !== 8'b0000_0000) $display("FAIL illegal_ur_clear got %b exp %b", obs, 8'b0000_0000);
        else pass_cnt++;
        go_frozen();
        freeze_req = 1'b1;
        step(1);
        total_cnt++;
        if (obs !== 8'b1001_0010) $display("FAIL illegal_fr_set got %b exp %b", obs, 8'b1001_0010);
        else pass_cnt++;
        freeze_req = 1'b0;
        step(1);
        total_cnt++;
        if (obs !== 8'b1000_0010) $display("FAIL illegal_fr_clear got %b exp %b", obs, 8'b1000_0010);
        else pass_cnt++;
    endtask

    task automatic test_both_rise();
        apply_reset();
        freeze_req = 1'b1;
        unfreeze_req = 1'b1;
        step(1);
        total_cnt++;
        if (obs !== 8'b0011_0000) $display("FAIL both_rise got %b exp %b", obs, 8'b0011_0000);
        else pass_cnt++;
        freeze_req = 1'b0;
        unfreeze_req = 1'b0;
        step(1);
        total_cnt++;
        if (obs !== 8'b0000_0000) $display("FAIL both_clear got %b exp %b", obs, 8'b0000_0000);
        else pass_cnt++;
    endtask

    task automatic test_async_reset();
        apply_reset();
        go_frozen();
        unfreeze_req = 1'b1;
        step(2);
        total_cnt++;
        if (obs !== 8'b0000_0010) $display("FAIL pre_reset_unfreezing got %b exp %b", obs, 8'b0000_0010);
        else pass_cnt++;
        #1;
        reset_n = 1'b0;
        #1;
        total_cnt++;
        if (obs !== 8'b0000_0000) $display("FAIL async_reset got %b exp %b", obs, 8'b0000_0000);
        else pass_cnt++;
        unfreeze_req = 1'b0;
        step(1);
        reset_n = 1'b1;
        freeze_req = 1'b1;
        step(1);
        total_cnt++;
        if (obs !== 8'b0000_0100) $display("FAIL post_reset_freeze got %b exp %b", obs, 8'b0000_0100);
        else pass_cnt++;
        freeze_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_freeze_ack();
        test_timeout();
        test_reset_and_unfreeze();
        test_illegal();
        test_both_rise();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
